// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: state encodings,
// operand limits and the MEM wait-counter width.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_INC    = 3'd2,
    S_MEM    = 3'd3,
    S_DECODE = 3'd4,
    S_EXEC   = 3'd5,
    S_JUMP   = 3'd6,
    S_HALTED = 3'd7
  } seqState_e;

  localparam logic [1:0] MAX_OPERANDS = 2'd2;
  localparam int         WAIT_W       = 4;

  // Decoder may report 3 operand bytes; the datapath only has two operand registers.
  function automatic logic [1:0] clampOperands(input logic [1:0] requested);
    logic [1:0] result;
    if (requested > MAX_OPERANDS) begin
      result = MAX_OPERANDS;
    end else begin
      result = requested;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_mem_wait_timer.sv
// Loadable down-counter that holds off memory sampling for a fixed
// number of cycles after each MEM entry.
module mem_wait_timer
  import pc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] loadValue,
  input  logic              decrement,
  output logic              done
);

  logic [WAIT_W-1:0] count_r;

  // Reload on request, otherwise count down towards zero and stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WAIT_W{1'b0}};
    end else if (load) begin
      count_r <= loadValue;
    end else if (decrement && (count_r != {WAIT_W{1'b0}})) begin
      count_r <= count_r - {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WAIT_W{1'b0}});

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/operand/execute sequencer driving the PC, MAR, memory read path
// and the instruction/operand register load strobes.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int STATE_W  = 3
) (
  input  logic               inCLK,
  input  logic               inRST,
  input  logic               inRun,
  input  logic               inMemReady,
  input  logic [1:0]         inOperandBytes,
  input  logic               inExecDone,
  input  logic               inJump,
  input  logic               inHalt,
  output logic               outPCEnOut,
  output logic               outPCInc,
  output logic               outPCLoad,
  output logic               outMARLoad,
  output logic               outMemRead,
  output logic               outIRLoad,
  output logic               outOpLoLoad,
  output logic               outOpHiLoad,
  output logic               outExecStart,
  output logic               outHalted,
  output logic [STATE_W-1:0] outState
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

  seqState_e  state_r;
  seqState_e  nextState_s;
  logic [1:0] byteIdx_r;
  logic [1:0] nextIdx_s;
  logic [1:0] opCount_r;
  logic [1:0] nextCount_s;
  logic       waitDone_s;
  logic       timerLoad_s;
  logic       timerDec_s;
  logic       memAccept_s;

  // INC always precedes MEM, so reloading there gives a fresh wait on every MEM entry.
  assign timerLoad_s = (state_r == S_INC);
  assign timerDec_s  = (state_r == S_MEM) && !waitDone_s;
  assign memAccept_s = (state_r == S_MEM) && waitDone_s && inMemReady;

  mem_wait_timer uWaitTimer (
    .clk       (inCLK),
    .rst_n     (inRST),
    .load      (timerLoad_s),
    .loadValue (WAIT_LOAD),
    .decrement (timerDec_s),
    .done      (waitDone_s)
  );

  // Load strobes must coincide with valid W-bus data, so they follow the accept condition directly.
  assign outIRLoad   = memAccept_s && (byteIdx_r == 2'd0);
  assign outOpLoLoad = memAccept_s && (byteIdx_r == 2'd1);
  assign outOpHiLoad = memAccept_s && (byteIdx_r == 2'd2);
  assign outState    = STATE_W'(state_r);

  // Next-state, byte-index and operand-count selection.
  always_comb begin
    nextState_s = state_r;
    nextIdx_s   = byteIdx_r;
    nextCount_s = opCount_r;
    case (state_r)
      S_IDLE: begin
        if (inRun) nextState_s = S_ADDR;
        else       nextState_s = S_IDLE;
      end
      S_ADDR: nextState_s = S_INC;
      S_INC:  nextState_s = S_MEM;
      S_MEM: begin
        if (!memAccept_s) begin
          nextState_s = S_MEM;
        end else if (byteIdx_r == 2'd0) begin
          nextState_s = S_DECODE;
        end else if (byteIdx_r == opCount_r) begin
          nextState_s = S_EXEC;
          nextIdx_s   = 2'd0;
        end else begin
          nextState_s = S_ADDR;
          nextIdx_s   = byteIdx_r + 2'd1;
        end
      end
      S_DECODE: begin
        nextCount_s = clampOperands(inOperandBytes);
        if (nextCount_s == 2'd0) begin
          nextState_s = S_EXEC;
        end else begin
          nextState_s = S_ADDR;
          nextIdx_s   = 2'd1;
        end
      end
      S_EXEC: begin
        if (!inExecDone)  nextState_s = S_EXEC;
        else if (inHalt)  nextState_s = S_HALTED;
        else if (inJump)  nextState_s = S_JUMP;
        else if (inRun)   nextState_s = S_ADDR;
        else              nextState_s = S_IDLE;
      end
      S_JUMP: begin
        if (inRun) nextState_s = S_ADDR;
        else       nextState_s = S_IDLE;
      end
      S_HALTED: begin
        if (inRun) nextState_s = S_HALTED;
        else       nextState_s = S_IDLE;
      end
      default: begin
        nextState_s = S_IDLE;
        nextIdx_s   = 2'd0;
      end
    endcase
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge inCLK or negedge inRST) begin
    if (!inRST) begin
      state_r      <= S_IDLE;
      byteIdx_r    <= 2'd0;
      opCount_r    <= 2'd0;
      outPCEnOut   <= 1'b0;
      outMARLoad   <= 1'b0;
      outPCInc     <= 1'b0;
      outMemRead   <= 1'b0;
      outPCLoad    <= 1'b0;
      outHalted    <= 1'b0;
      outExecStart <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      byteIdx_r    <= nextIdx_s;
      opCount_r    <= nextCount_s;
      outPCEnOut   <= (nextState_s == S_ADDR);
      outMARLoad   <= (nextState_s == S_ADDR);
      outPCInc     <= (nextState_s == S_INC);
      outMemRead   <= (nextState_s == S_MEM);
      outPCLoad    <= (nextState_s == S_JUMP);
      outHalted    <= (nextState_s == S_HALTED);
      outExecStart <= (nextState_s == S_EXEC) && (state_r != S_EXEC);
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: two sequencer instances (no memory wait and a
// two-cycle wait) checked every cycle against a step-plan reference model,
// plus directed scenarios with hand-computed expectations.
module tb_pc_fetch_sequencer;

  localparam int WAIT0 = 0;
  localparam int WAIT1 = 2;

  logic clk = 1'b0;
  logic rstN, run, memReady, execDone, jump, halt;
  logic [1:0] opBytes;
  logic [1:0] pcEn, pcInc, pcLoad, marLoad, memRead, irLoad, loLoad, hiLoad, execStart, halted;
  logic [2:0] st0, st1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.MEM_WAIT(WAIT0), .STATE_W(3)) d0 (
    .inCLK(clk), .inRST(rstN), .inRun(run), .inMemReady(memReady),
    .inOperandBytes(opBytes), .inExecDone(execDone), .inJump(jump), .inHalt(halt),
    .outPCEnOut(pcEn[0]), .outPCInc(pcInc[0]), .outPCLoad(pcLoad[0]),
    .outMARLoad(marLoad[0]), .outMemRead(memRead[0]), .outIRLoad(irLoad[0]),
    .outOpLoLoad(loLoad[0]), .outOpHiLoad(hiLoad[0]), .outExecStart(execStart[0]),
    .outHalted(halted[0]), .outState(st0)
  );

  pc_fetch_sequencer #(.MEM_WAIT(WAIT1), .STATE_W(3)) d1 (
    .inCLK(clk), .inRST(rstN), .inRun(run), .inMemReady(memReady),
    .inOperandBytes(opBytes), .inExecDone(execDone), .inJump(jump), .inHalt(halt),
    .outPCEnOut(pcEn[1]), .outPCInc(pcInc[1]), .outPCLoad(pcLoad[1]),
    .outMARLoad(marLoad[1]), .outMemRead(memRead[1]), .outIRLoad(irLoad[1]),
    .outOpLoLoad(loLoad[1]), .outOpHiLoad(hiLoad[1]), .outExecStart(execStart[1]),
    .outHalted(halted[1]), .outState(st1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance walks a plan of cycle kinds (1 ADDR, 2 INC, 3 MEM, 4 DECODE,
  // 5 EXEC, 6 JUMP, 7 HALTED, 0 IDLE); the tag is the byte a MEM step loads.
  int kindM[2], tagM[2], memCyc[2], execCyc[2], opCnt[2], incCnt[2], planN[2];
  int planK[2][16];
  int planT[2][16];

  function automatic int waitOf(input bit m);
    return (m == 1'b0) ? WAIT0 : WAIT1;
  endfunction

  function automatic void modelReset(input bit m);
    kindM[m] = 0; tagM[m] = 0; memCyc[m] = 0; execCyc[m] = 0;
    opCnt[m] = 0; incCnt[m] = 0; planN[m] = 0;
  endfunction

  function automatic void pushStep(input bit m, input int k, input int t);
    planK[m][planN[m]] = k;
    planT[m][planN[m]] = t;
    planN[m]++;
  endfunction

  function automatic void pushFetch(input bit m);
    pushStep(m, 1, 0); pushStep(m, 2, 0); pushStep(m, 3, 0); pushStep(m, 4, 0);
  endfunction

  function automatic void nextStep(input bit m);
    if (planN[m] == 0) begin
      kindM[m] = 0; tagM[m] = 0;
    end else begin
      kindM[m] = planK[m][0];
      tagM[m]  = planT[m][0];
      for (int i = 0; i < planN[m] - 1; i++) begin
        planK[m][i] = planK[m][i+1];
        planT[m][i] = planT[m][i+1];
      end
      planN[m]--;
    end
    memCyc[m] = 0;
    execCyc[m] = 0;
  endfunction

  function automatic logic [13:0] expVec(input bit m, input logic ready);
    int  k;
    int  t;
    logic acc;
    k = kindM[m];
    t = tagM[m];
    acc = (k == 3) && (memCyc[m] >= waitOf(m)) && ready;
    return {3'(k), (k == 1), (k == 2), (k == 6), (k == 1), (k == 3),
            acc && (t == 0), acc && (t == 1), acc && (t == 2),
            (k == 5) && (execCyc[m] == 0), (k == 7)};
  endfunction

  function automatic logic [13:0] actVec(input bit m);
    return {(m == 1'b0) ? st0 : st1, pcEn[m], pcInc[m], pcLoad[m], marLoad[m],
            memRead[m], irLoad[m], loLoad[m], hiLoad[m], execStart[m], halted[m]};
  endfunction

  function automatic void advance(input bit m);
    int n;
    case (kindM[m])
      0: if (run) begin pushFetch(m); nextStep(m); end
      1, 2: nextStep(m);
      3: begin
        if ((memCyc[m] >= waitOf(m)) && memReady) nextStep(m);
        else memCyc[m]++;
      end
      4: begin
        n = (int'(opBytes) > 2) ? 2 : int'(opBytes);
        opCnt[m] = n;
        for (int b = 1; b <= n; b++) begin
          pushStep(m, 1, b); pushStep(m, 2, b); pushStep(m, 3, b);
        end
        pushStep(m, 5, 0);
        nextStep(m);
      end
      5: begin
        if (execDone) begin
          if (halt)      pushStep(m, 7, 0);
          else if (jump) pushStep(m, 6, 0);
          else if (run)  pushFetch(m);
          else           pushStep(m, 0, 0);
          nextStep(m);
        end else begin
          execCyc[m]++;
        end
      end
      6: begin
        if (run) pushFetch(m);
        else     pushStep(m, 0, 0);
        nextStep(m);
      end
      7: if (!run) begin pushStep(m, 0, 0); nextStep(m); end
      default: ;
    endcase
  endfunction

  // Compare both instances against the model mid-cycle, then step the model
  // with the inputs the DUTs will sample at the coming rising edge.
  always @(negedge clk) begin
    logic [13:0] e;
    for (int i = 0; i < 2; i++) begin
      if (!rstN) modelReset(1'(i));
      e = expVec(1'(i), memReady);
      check($sformatf("outputs d%0d", i), int'(actVec(1'(i))), int'(e));
      check($sformatf("incLoadExcl d%0d", i), int'(pcInc[i] & pcLoad[i]), 0);
      check($sformatf("busExcl d%0d", i), int'(pcEn[i] & memRead[i]), 0);
      check($sformatf("loadOneHot d%0d", i),
            int'($countones({irLoad[i], loLoad[i], hiLoad[i]}) <= 1), 1);
      if (rstN) begin
        if (pcInc[i]) incCnt[i]++;
        if (e[1]) begin
          check($sformatf("incPerInstr d%0d", i), incCnt[i], 1 + opCnt[i]);
          incCnt[i] = 0;
        end
        advance(1'(i));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0; run = 1'b0; memReady = 1'b0; execDone = 1'b0;
    jump = 1'b0; halt = 1'b0; opBytes = 2'd0;
    tick();
    tick();
    check("resetOutputs d0", int'(actVec(1'b0)), 0);
    check("resetOutputs d1", int'(actVec(1'b1)), 0);
    rstN = 1'b1;
    #1;
    check("stateAfterRelease", int'(st0), 0);
  endtask

  int seq1[6] = '{1, 2, 3, 4, 5, 1};

  initial begin
    int incs, order, startCyc, memCnt, firstLoad, found, loadPat;

    // Single-byte instruction: state walk and strobe timing.
    doReset();
    run = 1'b1; opBytes = 2'd0; memReady = 1'b1;
    incs = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("seq1State", int'(st0), seq1[k]);
      if (k == 2) check("irAtMem", int'(irLoad[0]), 1);
      if (k < 5 && pcInc[0]) incs++;
      execDone = (k == 4);
    end
    execDone = 1'b0;
    check("seq1IncCount", incs, 1);

    // Two operand bytes: load order IR, OpLo, OpHi; three increments before start.
    doReset();
    run = 1'b1; opBytes = 2'd2; memReady = 1'b1;
    incs = 0; order = 0; startCyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pcInc[0]) incs++;
      if (irLoad[0]) order = order * 4 + 1;
      if (loLoad[0]) order = order * 4 + 2;
      if (hiLoad[0]) order = order * 4 + 3;
      if (execStart[0]) begin
        startCyc = k;
        break;
      end
    end
    check("opStartCycle", startCyc, 11);
    check("incsBeforeExec", incs, 3);
    check("loadOrder", order, 27);

    // Jump taken at the end of that instruction.
    execDone = 1'b1; jump = 1'b1;
    tick();
    check("jumpState", int'(st0), 6);
    check("jumpPCLoad", int'(pcLoad[0]), 1);
    check("jumpNoInc", int'(pcInc[0]), 0);
    execDone = 1'b0; jump = 1'b0;
    tick();
    check("afterJumpState", int'(st0), 1);
    check("afterJumpPCEn", int'(pcEn[0]), 1);

    // Two-cycle memory wait plus five not-ready cycles on instance d1.
    doReset();
    run = 1'b1; opBytes = 2'd0; memReady = 1'b0;
    memCnt = 0; firstLoad = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      memReady = (k == 10);
      #1;
      if (memRead[1]) memCnt++;
      if (firstLoad == 0 && (irLoad[1] | loLoad[1] | hiLoad[1])) firstLoad = k;
    end
    check("waitMemReadCycles", memCnt, 8);
    check("waitFirstLoadCycle", firstLoad, 10);

    // Halt, hold while running, leave on run low, restart on run high.
    doReset();
    run = 1'b1; opBytes = 2'd0; memReady = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (st0 == 3'd5) begin
        found = 1;
        break;
      end
    end
    check("reachExec", found, 1);
    execDone = 1'b1; halt = 1'b1;
    tick();
    check("haltState", int'(st0), 7);
    check("haltFlag", int'(halted[0]), 1);
    execDone = 1'b0; halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("haltHold", int'(halted[0]), 1);
    end
    run = 1'b0;
    tick();
    check("haltToIdle", int'(st0), 0);
    run = 1'b1;
    tick();
    check("restartAddr", int'(st0), 1);

    // Reset while waiting in MEM for the first operand byte.
    doReset();
    run = 1'b1; opBytes = 2'd1; memReady = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) memReady = 1'b0;
    end
    check("memIdx1State", int'(st0), 3);
    #2;
    rstN = 1'b0;
    #1;
    check("asyncResetD0", int'(actVec(1'b0)), 0);
    check("asyncResetD1", int'(actVec(1'b1)), 0);
    tick();
    opBytes = 2'd0; memReady = 1'b1; rstN = 1'b1;
    #1;
    check("releaseState", int'(st0), 0);
    loadPat = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (irLoad[0] | loLoad[0] | hiLoad[0]) begin
        loadPat = int'({irLoad[0], loLoad[0], hiLoad[0]});
        break;
      end
    end
    check("firstFetchIR", loadPat, 4);

    // Randomized run with occasional resets.
    doReset();
    for (int k = 0; k < 4000; k++) begin
      tick();
      rstN     = ($urandom % 400) != 0;
      run      = ($urandom % 10) != 0;
      memReady = ($urandom % 10) < 7;
      execDone = ($urandom % 10) < 4;
      jump     = ($urandom % 10) < 3;
      halt     = ($urandom % 20) == 0;
      opBytes  = 2'($urandom % 4);
    end
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
